// File: rtl/rr_pkg_0001.sv
// Shared types and helpers for the round-robin grant controller.
package rr_pkg_0001;

    localparam int unsigned NUM_PORTS_DEF = 4;

    typedef enum logic {IDLE, LOCKED} rr_state_t;

    typedef logic [NUM_PORTS_DEF-1:0] port_vec_t;

    // Index of the single set bit among the low n bits; anything not one-hot maps to 0.
    function automatic int unsigned onehot2idx(input logic [31:0] vec, input int unsigned n);
        int unsigned idx;
        int unsigned ones;
        idx  = 0;
        ones = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n && vec[i]) begin
                ones = ones + 1;
                idx  = i;
            end
        end
        return (ones == 1) ? idx : 0;
    endfunction

endpackage

// File: rtl/rr_pick_0001.sv
// Combinational rotate-and-priority-encode: first requester at or after the priority index.
module rr_pick_0001
    import rr_pkg_0001::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_priority_order,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [IDX_W-1:0]     o_winner,
    output logic                 o_any_req
);

    int unsigned w_start;
    int unsigned w_idx;
    logic        w_found;

    assign o_any_req = |i_req;

    // Scan from the priority index upward, wrapping, and keep the first requester.
    always_comb begin
        w_start  = onehot2idx(32'(i_priority_order), NUM_PORTS);
        w_idx    = 0;
        w_found  = 1'b0;
        o_winner = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_idx = (w_start + k) % NUM_PORTS;
            if (!w_found && i_req[IDX_W'(w_idx)]) begin
                w_found  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl_0001.sv
// Wormhole grant controller: locks one input port per packet and steers its flit handshake.
module rr_grant_ctrl_0001
    import rr_pkg_0001::*;
#(
    parameter int unsigned NUM_PORTS     = NUM_PORTS_DEF,
    parameter int unsigned MAX_PKT_FLITS = 16,
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned CNT_W = $clog2(MAX_PKT_FLITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] priority_order_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic [NUM_PORTS-1:0] tail_i,
    output logic [NUM_PORTS-1:0] ready_o,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic                 out_tail_o,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     sel_o,
    output logic                 change_order_o,
    output logic                 err_o
);

    rr_state_t            r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [IDX_W-1:0]     r_sel;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;

    logic [IDX_W-1:0]     w_winner;
    logic                 w_any_req;
    logic                 w_locked;
    logic                 w_xfer;
    logic                 w_at_limit;
    logic                 w_release;
    logic                 w_overflow;

    rr_pick_0001 #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .i_priority_order (priority_order_i),
        .i_req            (req_i),
        .o_winner         (w_winner),
        .o_any_req        (w_any_req)
    );

    // Handshake decode for the locked port; release on tail or on reaching the flit limit.
    always_comb begin
        w_locked   = (r_state == LOCKED);
        w_xfer     = w_locked & valid_i[r_sel] & out_ready_i;
        w_at_limit = (r_cnt == CNT_W'(MAX_PKT_FLITS - 1));
        w_release  = w_xfer & (tail_i[r_sel] | w_at_limit);
        // A tail arriving exactly at the limit is a legal packet, not an overflow.
        w_overflow = w_xfer & ~tail_i[r_sel] & w_at_limit;
    end

    // Output steering; the rotate pulse is suppressed while reset is asserted.
    always_comb begin
        ready_o        = r_grant & {NUM_PORTS{out_ready_i}};
        out_valid_o    = w_locked & valid_i[r_sel];
        out_tail_o     = w_locked & tail_i[r_sel];
        change_order_o = w_release & ~reset;
        grant_o        = r_grant;
        sel_o          = r_sel;
        err_o          = r_err;
    end

    // Grant FSM with flit counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= LOCKED;
                        r_grant <= {{(NUM_PORTS - 1){1'b0}}, 1'b1} << w_winner;
                        r_sel   <= w_winner;
                        r_cnt   <= '0;
                    end
                end
                LOCKED: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_sel   <= '0;
                        r_cnt   <= '0;
                        if (w_overflow) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
